// File: rtl/gerenciador_ataque_sync_pkg.sv
// Shared geometry and column-word type for the attack manager.
package gerenciador_ataque_sync_pkg;

  localparam int unsigned NUM_COLS = 5;
  localparam int unsigned NUM_ROWS = 7;
  localparam int unsigned COORD_W  = 3;

  // One column of the LED matrix; bit r = row r.
  typedef logic [NUM_ROWS-1:0] coluna_t;

endpackage

// File: rtl/FF_d.sv
// Rising-edge D flip-flop with synchronous active-high clear.
module FF_d (
  input  logic d,
  input  logic clk,
  input  logic reset,
  output logic q
);

  // Capture d every clock; reset forces zero.
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: rtl/comparador_de_igualdade.sv
// Equality comparator for two column words.
module comparador_de_igualdade
  import gerenciador_ataque_sync_pkg::*;
(
  input  coluna_t a,
  input  coluna_t b,
  output logic    eq
);

  // High when both words match bit for bit.
  always_comb begin
    eq = (a == b);
  end

endmodule

// File: rtl/decodificador_3bits.sv
// 3-bit selector to one-hot decoder, purely combinational.
module decodificador_3bits
  import gerenciador_ataque_sync_pkg::*;
(
  input  logic [COORD_W-1:0]      sel,
  output logic [(1<<COORD_W)-1:0] s
);

  // Raise exactly the output addressed by sel.
  always_comb begin
    s      = '0;
    s[sel] = 1'b1;
  end

endmodule

// File: rtl/gerenciador_ataque_sync.sv
// Battleship attack manager: reveals hidden-map cells on each fire edge and
// reports new hit (green) versus miss/repeat/out-of-range (red).
module gerenciador_ataque_sync
  import gerenciador_ataque_sync_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] coordColuna,
  input  logic [COORD_W-1:0] coordLinha,
  input  logic               enable,
  input  logic               confirmar,
  input  coluna_t            mapa0,
  input  coluna_t            mapa1,
  input  coluna_t            mapa2,
  input  coluna_t            mapa3,
  input  coluna_t            mapa4,
  output coluna_t            matriz0,
  output coluna_t            matriz1,
  output coluna_t            matriz2,
  output coluna_t            matriz3,
  output coluna_t            matriz4,
  output logic               LED_R,
  output logic               LED_G,
  output logic               LED_B
);

  logic [(1<<COORD_W)-1:0] col_sel;
  logic [(1<<COORD_W)-1:0] lin_sel;
  coluna_t                 mapa     [NUM_COLS];
  coluna_t                 matriz_q [NUM_COLS];
  coluna_t                 matriz_d [NUM_COLS];
  coluna_t                 nxt      [NUM_COLS];
  logic [NUM_COLS-1:0]     eq;
  logic                    igual;
  logic                    conf_q;
  logic                    shot;
  logic                    led_r_d;
  logic                    led_g_d;
  logic                    led_r_q;
  logic                    led_g_q;
  logic                    unused_sel;

  assign mapa[0] = mapa0;
  assign mapa[1] = mapa1;
  assign mapa[2] = mapa2;
  assign mapa[3] = mapa3;
  assign mapa[4] = mapa4;

  decodificador_3bits u_dec_col (
    .sel (coordColuna),
    .s   (col_sel)
  );

  decodificador_3bits u_dec_lin (
    .sel (coordLinha),
    .s   (lin_sel)
  );

  // Columns 5..7 and row 7 select no cell, so those decode lines are unused.
  assign unused_sel = ^{col_sel[7:5], lin_sel[7]};

  // Candidate matrix: the addressed cell takes the map bit, all others hold.
  always_comb begin
    for (int unsigned k = 0; k < NUM_COLS; k++) begin
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
        nxt[k][r] = (col_sel[k] & lin_sel[r]) ? mapa[k][r] : matriz_q[k][r];
      end
    end
  end

  for (genvar k = 0; k < NUM_COLS; k++) begin : g_cmp
    comparador_de_igualdade u_cmp (
      .a  (nxt[k]),
      .b  (matriz_q[k]),
      .eq (eq[k])
    );
  end

  assign igual = &eq;
  assign shot  = confirmar & ~conf_q;

  // Fire-button history; tracks the button even while the game is disabled.
  always_ff @(posedge clk) begin
    if (reset) conf_q <= 1'b0;
    else       conf_q <= confirmar;
  end

  // Next matrix and LED values: clear when disabled, update on a shot, else hold.
  always_comb begin
    matriz_d = matriz_q;
    led_r_d  = led_r_q;
    led_g_d  = led_g_q;
    if (!enable) begin
      for (int unsigned k = 0; k < NUM_COLS; k++) matriz_d[k] = '0;
      led_r_d = 1'b0;
      led_g_d = 1'b0;
    end else if (shot) begin
      matriz_d = nxt;
      led_r_d  = igual;
      led_g_d  = ~igual;
    end
  end

  // Revealed-matrix registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_COLS; k++) matriz_q[k] <= '0;
    end else begin
      matriz_q <= matriz_d;
    end
  end

  FF_d u_ff_r (
    .d     (led_r_d),
    .clk   (clk),
    .reset (reset),
    .q     (led_r_q)
  );

  FF_d u_ff_g (
    .d     (led_g_d),
    .clk   (clk),
    .reset (reset),
    .q     (led_g_q)
  );

  assign matriz0 = matriz_q[0];
  assign matriz1 = matriz_q[1];
  assign matriz2 = matriz_q[2];
  assign matriz3 = matriz_q[3];
  assign matriz4 = matriz_q[4];
  assign LED_R   = led_r_q;
  assign LED_G   = led_g_q;
  assign LED_B   = 1'b0;

endmodule

// File: tb/tb_gerenciador_ataque_sync.sv
// Self-checking bench: directed scenarios then random play against a
// cell-level model of the game rules.
module tb_gerenciador_ataque_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] coordColuna;
  logic [2:0] coordLinha;
  logic       enable;
  logic       confirmar;
  logic [6:0] mapa [5];
  logic [6:0] matriz [5];
  logic       LED_R, LED_G, LED_B;

  int checks = 0;
  int errors = 0;

  // Reference model state: which cells are revealed, LED state, button history.
  bit revealed [5][7];
  bit exp_r, exp_g;
  bit prev_conf;

  always #5 clk = ~clk;

  gerenciador_ataque_sync dut (
    .clk         (clk),
    .reset       (reset),
    .coordColuna (coordColuna),
    .coordLinha  (coordLinha),
    .enable      (enable),
    .confirmar   (confirmar),
    .mapa0       (mapa[0]),
    .mapa1       (mapa[1]),
    .mapa2       (mapa[2]),
    .mapa3       (mapa[3]),
    .mapa4       (mapa[4]),
    .matriz0     (matriz[0]),
    .matriz1     (matriz[1]),
    .matriz2     (matriz[2]),
    .matriz3     (matriz[3]),
    .matriz4     (matriz[4]),
    .LED_R       (LED_R),
    .LED_G       (LED_G),
    .LED_B       (LED_B)
  );

  task automatic model_clear();
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++) revealed[c][r] = 1'b0;
    exp_r = 1'b0;
    exp_g = 1'b0;
  endtask

  // Apply the game rules for one clock edge using the inputs present at it.
  task automatic model_step();
    int c, r;
    if (reset) begin
      model_clear();
      prev_conf = 1'b0;
    end else begin
      if (!enable) begin
        model_clear();
      end else if (confirmar && !prev_conf) begin
        c = int'(coordColuna);
        r = int'(coordLinha);
        if (c < 5 && r < 7) begin
          exp_g = mapa[c][r] && !revealed[c][r];
          exp_r = !exp_g;
          if (mapa[c][r]) revealed[c][r] = 1'b1;
        end else begin
          exp_r = 1'b1;
          exp_g = 1'b0;
        end
      end
      prev_conf = confirmar;
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string step);
    logic [6:0] w;
    for (int c = 0; c < 5; c++) begin
      w = '0;
      for (int r = 0; r < 7; r++) w[r] = revealed[c][r];
      chk($sformatf("%s matriz%0d", step, c), matriz[c], w);
    end
    chk({step, " LED_R"}, {6'b0, LED_R}, {6'b0, exp_r});
    chk({step, " LED_G"}, {6'b0, LED_G}, {6'b0, exp_g});
    chk({step, " LED_B"}, {6'b0, LED_B}, 7'd0);
  endtask

  // One clock: model follows the edge, outputs are compared at the falling edge.
  task automatic tick(input string step);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(step);
  endtask

  task automatic shot(input int c, input int r, input string step);
    coordColuna = 3'(c);
    coordLinha  = 3'(r);
    confirmar   = 1'b1;
    tick(step);
    confirmar   = 1'b0;
    tick({step, "_rel"});
  endtask

  initial begin
    mapa[0] = 7'b1110001;
    mapa[1] = 7'b0100000;
    mapa[2] = 7'b0000000;
    mapa[3] = 7'b0000000;
    mapa[4] = 7'b1110000;
    reset = 1'b1;
    enable = 1'b1;
    confirmar = 1'b0;
    coordColuna = '0;
    coordLinha = '0;
    prev_conf = 1'b0;
    model_clear();
    @(negedge clk);
    tick("reset");
    reset = 1'b0;
    tick("post_reset");

    shot(0, 0, "hit_0_0");
    shot(0, 1, "miss_0_1");
    shot(1, 5, "hit_1_5");
    shot(3, 5, "miss_3_5");
    shot(4, 6, "hit_4_6");
    shot(4, 6, "repeat_4_6");
    shot(5, 0, "oor_col");
    shot(0, 7, "oor_row");
    shot(0, 0, "repeat_0_0");

    // Held button with moving coordinates fires once.
    coordColuna = 3'd0;
    coordLinha  = 3'd4;
    confirmar   = 1'b1;
    tick("hold0");
    for (int i = 0; i < 4; i++) begin
      coordColuna = 3'(i);
      coordLinha  = 3'(6 - i);
      tick("hold");
    end
    confirmar = 1'b0;
    tick("hold_rel");

    // Disable for one cycle clears everything.
    enable = 1'b0;
    tick("disable");
    enable = 1'b1;
    shot(0, 0, "reenable_hit");

    // Button held across re-enable does not fire.
    coordColuna = 3'd4;
    coordLinha  = 3'd5;
    enable    = 1'b0;
    confirmar = 1'b1;
    tick("dis_held");
    enable = 1'b1;
    tick("en_held");
    confirmar = 1'b0;
    tick("en_rel");

    // Reset coincident with a shot edge.
    coordColuna = 3'd4;
    coordLinha  = 3'd4;
    confirmar   = 1'b1;
    reset       = 1'b1;
    tick("reset_vs_shot");
    reset     = 1'b0;
    confirmar = 1'b0;
    tick("after_reset");

    // Random play with random maps.
    for (int i = 0; i < 5; i++) mapa[i] = 7'($urandom);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 50) confirmar = ~confirmar;
      coordColuna = 3'($urandom_range(0, 7));
      coordLinha  = 3'($urandom_range(0, 7));
      enable      = ($urandom_range(0, 99) >= 4);
      reset       = ($urandom_range(0, 99) < 2);
      if (n % 100 == 99) mapa[$urandom_range(0, 4)] = 7'($urandom);
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
